// File: rtl/cla_add16_pipe.sv
// 16-bit two-stage adder: stage 1 registers bit propagate/generate, stage 2 resolves a
// 4x4 carry-lookahead tree and registers sum/cout/ovf/P/G. Valid/ready on both sides.
module cla_add16_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf,
  output logic        P,
  output logic        G
);

  logic        s1_valid_q;
  logic [15:0] p_q, g_q;
  logic        c0_q;

  logic        out_valid_q;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        bp_q, bp_d;
  logic        bg_q, bg_d;

  logic        adv2;
  logic [3:0]  grp_p, grp_g;
  logic        c4, c8, c12, c16;
  logic [3:0]  grp_cin;
  logic [15:0] carry;

  // Stage 2 moves whenever its slot is free or being drained; stage 1 follows.
  assign adv2     = s1_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !s1_valid_q || !out_valid_q || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      p_q        <= '0;
      g_q        <= '0;
      c0_q       <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        p_q  <= a ^ b;
        g_q  <= a & b;
        c0_q <= cin;
      end
    end
  end

  always_comb begin
    grp_p = '0;
    grp_g = '0;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &p_q[4*k +: 4];
      grp_g[k] = g_q[4*k+3]
               | (p_q[4*k+3] & g_q[4*k+2])
               | (p_q[4*k+3] & p_q[4*k+2] & g_q[4*k+1])
               | (p_q[4*k+3] & p_q[4*k+2] & p_q[4*k+1] & g_q[4*k]);
    end
  end

  assign c4      = grp_g[0] | (grp_p[0] & c0_q);
  assign c8      = grp_g[1] | (grp_p[1] & c4);
  assign c12     = grp_g[2] | (grp_p[2] & c8);
  assign c16     = grp_g[3] | (grp_p[3] & c12);
  assign grp_cin = {c12, c8, c4, c0_q};

  // carry[i] is the carry into bit i, each resolved in two-level lookahead form from its group carry.
  always_comb begin
    carry = '0;
    for (int k = 0; k < 4; k++) begin
      carry[4*k]   = grp_cin[k];
      carry[4*k+1] = g_q[4*k] | (p_q[4*k] & grp_cin[k]);
      carry[4*k+2] = g_q[4*k+1]
                   | (p_q[4*k+1] & g_q[4*k])
                   | (p_q[4*k+1] & p_q[4*k] & grp_cin[k]);
      carry[4*k+3] = g_q[4*k+2]
                   | (p_q[4*k+2] & g_q[4*k+1])
                   | (p_q[4*k+2] & p_q[4*k+1] & g_q[4*k])
                   | (p_q[4*k+2] & p_q[4*k+1] & p_q[4*k] & grp_cin[k]);
    end
  end

  assign sum_d  = p_q ^ carry;
  assign cout_d = c16;
  assign ovf_d  = c16 ^ carry[15];
  assign bp_d   = &grp_p;
  assign bg_d   = grp_g[3]
                | (grp_p[3] & grp_g[2])
                | (grp_p[3] & grp_p[2] & grp_g[1])
                | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      bp_q        <= 1'b0;
      bg_q        <= 1'b0;
    end else if (adv2) begin
      out_valid_q <= 1'b1;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      bp_q        <= bp_d;
      bg_q        <= bg_d;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign P         = bp_q;
  assign G         = bg_q;

endmodule

// File: tb/tb_cla_add16_pipe.sv
// Scoreboard bench for cla_add16_pipe: expected results queued at input transfer,
// compared at the output; directed corner vectors, back-pressure, reset flush, random traffic.
module tb_cla_add16_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, ovf, P, G;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  logic [19:0] exp_q[$];

  always #5 clk = ~clk;

  cla_add16_pipe dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .P(P), .G(G)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Result packed as {ovf, P, G, cout, sum}.
  function automatic logic [19:0] model(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    logic [16:0] s;
    logic [16:0] s0;
    logic        v;
    s  = {1'b0, ta} + {1'b0, tb} + {16'b0, tc};
    s0 = {1'b0, ta} + {1'b0, tb};
    v  = (ta[15] == tb[15]) && (s[15] != ta[15]);
    return {v, &(ta ^ tb), s0[16], s[16], s[15:0]};
  endfunction

  function automatic logic [19:0] observed();
    return {ovf, P, G, cout, sum};
  endfunction

  task automatic monitor();
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {31'b0, out_valid}, 32'd0);
      end else begin
        check("result", {12'b0, observed()}, {12'b0, exp_q[0]});
        if (out_ready) void'(exp_q.pop_front());
      end
    end
    if (!rst && in_valid && in_ready) begin
      exp_q.push_back(model(a, b, cin));
      n_acc++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Offer one beat with out_ready high; result is visible two cycles after it is presented.
  task automatic send_one(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    check("lat_not_early", {31'b0, out_valid}, 32'd0);
    step();
    check("lat_two", {31'b0, out_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0;
    step(); step();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_sum", {16'b0, sum}, 32'd0);
    check("rst_flags", {27'b0, cout, ovf, P, G, 1'b0}, 32'd0);
    rst = 1'b0;

    send_one(16'h0001, 16'h0002, 1'b0);
    check("v1", {12'b0, observed()}, {12'b0, 4'b0000, 16'h0003});
    send_one(16'hFFFF, 16'h0000, 1'b1);
    check("v2_sum", {16'b0, sum}, 32'h0000);
    check("v2_cout_P_G", {29'b0, cout, P, G}, {29'b0, 3'b110});
    send_one(16'hFFFF, 16'h0000, 1'b0);
    check("v3_sum", {16'b0, sum}, 32'hFFFF);
    check("v3_cout", {31'b0, cout}, 32'd0);
    send_one(16'h7FFF, 16'h0001, 1'b0);
    check("v4_sum", {16'b0, sum}, 32'h8000);
    check("v4_ovf_cout", {30'b0, ovf, cout}, {30'b0, 2'b10});
    send_one(16'h8000, 16'h8000, 1'b0);
    check("v5_sum", {16'b0, sum}, 32'h0000);
    check("v5_cout_ovf_G", {29'b0, cout, ovf, G}, {29'b0, 3'b111});
    step();
    drain();

    // Back-pressure: three back-to-back beats against a stalled consumer.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    step();
    check("bp_ready_1", {31'b0, in_ready}, 32'd1);
    a = 16'h0F0F; b = 16'h00F1; cin = 1'b1;
    step();
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1;
    check("bp_ready_drop", {31'b0, in_ready}, 32'd0);
    step(); step();
    check("bp_ready_held", {31'b0, in_ready}, 32'd0);
    check("bp_hold_valid", {31'b0, out_valid}, 32'd1);
    check("bp_hold_sum", {16'b0, sum}, 32'h3333);
    out_ready = 1'b1;
    begin
      int start;
      start = n_acc;
      for (int i = 0; i < 10 && n_acc == start; i++) step();
      check("bp_third_accepted", n_acc - start, 32'd1);
    end
    in_valid = 1'b0;
    drain();

    // Reset with two beats in flight: both must vanish at once.
    out_ready = 1'b0;
    in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b0;
    step();
    a = 16'h0102; b = 16'h0304;
    step();
    in_valid = 1'b0;
    check("flush_pre_valid", {31'b0, out_valid}, 32'd1);
    check("flush_pre_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    check("flush_sum", {16'b0, sum}, 32'd0);
    check("flush_ready", {31'b0, in_ready}, 32'd1);
    exp_q.delete();
    out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    in_valid = 1'b1; a = 16'h0005; b = 16'h0007; cin = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("post_rst_valid", {31'b0, out_valid}, 32'd1);
    check("post_rst_sum", {16'b0, sum}, 32'h000D);
    for (int i = 0; i < 6; i++) step();
    check("post_rst_empty", exp_q.size(), 32'd0);

    // Random traffic with random stalls on both sides.
    begin
      int base;
      int cyc;
      base = n_acc;
      cyc  = 0;
      while (n_acc - base < 10000 && cyc < 60000) begin
        case ($urandom_range(0, 5))
          0: a = 16'hFFFF;
          1: a = 16'h8000;
          2: a = 16'h7FFF;
          default: a = 16'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0: b = 16'h0000;
          1: b = ~a;
          2: b = 16'h8000;
          default: b = 16'($urandom);
        endcase
        cin       = 1'($urandom_range(0, 1));
        in_valid  = ($urandom_range(0, 3) != 0);
        out_ready = ($urandom_range(0, 3) != 0);
        step();
        cyc++;
      end
      check("rand_count", n_acc - base, 32'd10000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
